iq_rxd_deframer: RTL
====================

IQ_RXD_DEFRAMER -- requirements
Module: iq_rxd_deframer

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'h1ACF_FC1D: frame sync pattern, MSB-first.
REQ-002 SHALL have parameter FRAME_WORDS, default 12: payload words per frame; legal range 1..255.
REQ-003 SHALL have port clk32  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port iq_rxd  input  2: received IQ symbol, {I,Q}.
REQ-006 SHALL have port iq_en  input  1: iq_rxd is valid this cycle; symbols are ignored when low.
REQ-007 SHALL have port M_AXIS_tdata  output  32: assembled payload word.
REQ-008 SHALL have port M_AXIS_tvalid  output  1: tdata, tlast valid.
REQ-009 SHALL have port M_AXIS_tready  input  1: downstream accept.
REQ-010 SHALL have port M_AXIS_tlast  output  1: last word of frame.
REQ-011 SHALL have port locked  output  1: high while in COLLECT.
REQ-012 SHALL have port overflow  output  1: sticky, set on any dropped word.
REQ-013 SHALL have port frame_cnt  output  16: completed-frame count (see Configuration).

Function
REQ-014 SHALL use symbol order MSB-first: first symbol of a word maps to bits [31:30], 16th to [1:0].
REQ-015 SHALL keep a 32-bit shift register sreg, updated only on iq_en: sreg <= {sreg[29:0], iq_rxd}.
REQ-016 SHALL implement states HUNT and COLLECT; reset enters HUNT.
REQ-017 In HUNT, SHALL enter COLLECT on the cycle after an iq_en cycle where {sreg[29:0], iq_rxd} == SYNC_WORD; symbol counter = 0, word counter = 0.
REQ-018 In COLLECT, SHALL count iq_en symbols 0..15; on the 16th, the assembled word SHALL be presented on M_AXIS_tdata with tvalid high the following cycle (latency 1 clk32).
REQ-019 SHALL assert M_AXIS_tlast with word number FRAME_WORDS, then return to HUNT with sreg cleared to 0; the next frame requires a full new sync word.
REQ-020 SHALL hold tdata/tlast/tvalid stable while tvalid && !tready; tvalid deasserts the cycle after a tready handshake unless a new word loads that same cycle.
REQ-021 If a word completes while tvalid && !tready, SHALL drop the new word, keep the held word, set overflow; word counting and tlast position SHALL still advance.
REQ-022 If a word completes in the same cycle as a handshake of the held word, SHALL load the new word with no drop and no overflow.
REQ-023 iq_en low SHALL pause symbol counting and sync matching without state change.
REQ-024 locked SHALL be registered: high exactly in COLLECT.

Reset
REQ-025 On reset high at a clk32 edge, SHALL clear state to HUNT, sreg, counters, M_AXIS_tdata, tvalid, tlast, locked, overflow and frame_cnt to 0, even mid-frame or mid-handshake.
REQ-026 A partially assembled word at reset SHALL be discarded.

Configuration
REQ-027 Macro IQ_RXD_FRAME_CNT_EN defined: frame_cnt SHALL increment on every tlast handshake, saturating at 16'hFFFF.
REQ-028 Macro IQ_RXD_FRAME_CNT_EN undefined: frame_cnt SHALL be tied to 16'h0000 with no counter logic.

Verification
REQ-029 Sync 0x1ACFFC1D then 16 symbols 2'b01, tready=1 -> tdata=0x55555555, tvalid high 1 cycle after 16th symbol, locked=1.
REQ-030 Sync then 8 symbols 2'b00 + 8 symbols 2'b11 -> tdata=0x0000FFFF; then 0xFFFF0000 -> tdata=0xFFFF0000.
REQ-031 Sync + 12 words alternating 0x55555555/0x0000FFFF/0xFFFF0000, iq_en toggling 50% -> 12 words out in order, tlast only on 12th, locked falls, frame_cnt=1 (macro on) or 0 (off).
REQ-032 tready=0 for 40 cycles across two word completions -> first word held, second dropped, overflow=1 until reset.
REQ-033 Reset asserted at symbol 7 of word 5 -> next cycle tvalid=0, locked=0, overflow=0; a new sync restarts a clean frame.
REQ-034 Sync pattern with one symbol flipped -> stays in HUNT, no tvalid.

Source files
------------

// File: rtl/iq_rxd_deframer.sv
// IQ symbol deframer: hunts for a 32-bit sync word, then packs 16 two-bit symbols per word onto AXI-Stream.
// Optional completed-frame counter enabled by defining IQ_RXD_FRAME_CNT_EN.
module iq_rxd_deframer #(
  parameter logic [31:0] SYNC_WORD   = 32'h1ACF_FC1D,
  parameter int          FRAME_WORDS = 12
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic [1:0]  iq_rxd,
  input  logic        iq_en,
  output logic [31:0] M_AXIS_tdata,
  output logic        M_AXIS_tvalid,
  input  logic        M_AXIS_tready,
  output logic        M_AXIS_tlast,
  output logic        locked,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  // state   | meaning
  // HUNT    | searching the symbol stream for SYNC_WORD
  // COLLECT | packing payload symbols into words until FRAME_WORDS are done
  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS - 1);

  state_t      state, state_nxt;
  logic [31:0] sreg;
  logic [31:0] sreg_shift;
  logic [3:0]  sym_cnt;
  logic [7:0]  word_cnt;
  logic        sync_hit;
  logic        word_done;
  logic        frame_end;
  logic        handshake;
  logic        can_load;

  assign sreg_shift = {sreg[29:0], iq_rxd};
  assign sync_hit   = (state == HUNT) && iq_en && (sreg_shift == SYNC_WORD);
  assign word_done  = (state == COLLECT) && iq_en && (sym_cnt == 4'd15);
  assign frame_end  = word_done && (word_cnt == LAST_WORD);
  assign handshake  = M_AXIS_tvalid && M_AXIS_tready;
  assign can_load   = !M_AXIS_tvalid || M_AXIS_tready;

  always_ff @(posedge clk32) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (sync_hit)  state_nxt = COLLECT;
      COLLECT: if (frame_end) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    locked = (state == COLLECT);
  end

  // Clearing sreg at frame end forces the next frame to present a complete sync word.
  always_ff @(posedge clk32) begin
    if (reset) begin
      sreg     <= 32'h0;
      sym_cnt  <= 4'd0;
      word_cnt <= 8'd0;
    end else begin
      if (frame_end)  sreg <= 32'h0;
      else if (iq_en) sreg <= sreg_shift;

      if (sync_hit) begin
        sym_cnt  <= 4'd0;
        word_cnt <= 8'd0;
      end else if ((state == COLLECT) && iq_en) begin
        sym_cnt <= sym_cnt + 4'd1;
        if (word_done) word_cnt <= frame_end ? 8'd0 : word_cnt + 8'd1;
      end
    end
  end

  // A word finishing while the held word is stalled is lost; counting still advances.
  always_ff @(posedge clk32) begin
    if (reset) begin
      M_AXIS_tdata  <= 32'h0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else if (word_done && can_load) begin
      M_AXIS_tdata  <= sreg_shift;
      M_AXIS_tlast  <= frame_end;
      M_AXIS_tvalid <= 1'b1;
    end else if (word_done) begin
      overflow <= 1'b1;
    end else if (handshake) begin
      M_AXIS_tvalid <= 1'b0;
    end
  end

`ifdef IQ_RXD_FRAME_CNT_EN
  always_ff @(posedge clk32) begin
    if (reset)
      frame_cnt <= 16'h0;
    else if (handshake && M_AXIS_tlast && (frame_cnt != 16'hFFFF))
      frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule
